ifetch32_seq: RTL
=================

# ifetch32_seq

Instruction fetch sequencer for the 32-bit single-issue MIPS core. It sits upstream of the instruction decoder. It holds the PC and fetches words from instruction memory over a req/ack handshake. It presents `Instruction` and `opcplus4` to the decoder under a valid/ready handshake, then selects the next PC from the sequential, branch, jump, JAL and JR controls sampled at hand-off.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: byte address fetched first after reset; bits [1:0] must be 0.

Ports:
- `clock`  in  1  system clock; all state changes on its rising edge
- `reset`  in  1  asynchronous, active-low reset
- `imem_req`  out  1  fetch request; held until `imem_ack`
- `imem_addr`  out  32  byte address of the requested word; equals PC
- `imem_ack`  in  1  memory has `imem_rdata` valid this cycle
- `imem_rdata`  in  32  instruction word from memory
- `Instruction`  out  32  fetched instruction presented to the decoder
- `opcplus4`  out  32  PC+4 of the presented instruction (JAL link value)
- `inst_valid`  out  1  `Instruction`/`opcplus4` valid
- `inst_ready`  in  1  decoder/control accepts the presented instruction
- `Branch`  in  1  beq-type branch
- `nBranch`  in  1  bne-type branch
- `Zero`  in  1  ALU zero flag
- `Jmp`  in  1  j instruction
- `Jal`  in  1  jal instruction
- `Jrn`  in  1  jr instruction
- `Add_result`  in  32  branch target byte address
- `Read_data_1`  in  32  jr target (rs value)
- `fetch_fault`  out  1  misaligned target trap (see Configuration)

## Operation
- FSM states: FETCH, HOLD, FAULT.
- **Reset state.** While `reset`=0:
  - PC=`RESET_PC`, state=FETCH;
  - `imem_req`=0, `Instruction`=0, `opcplus4`=0, `inst_valid`=0, `fetch_fault`=0.
- **FETCH.**
  - `imem_req`=1, `imem_addr`=PC.
  - On a clock edge with `imem_ack`=1: `Instruction`<=`imem_rdata`, `opcplus4`<=PC+4, state<=HOLD.
- **HOLD.**
  - `inst_valid`=1, `imem_req`=0.
  - `Instruction` and `opcplus4` stay stable until accepted.
  - Accept = `inst_valid` & `inst_ready` at a clock edge. On accept: PC<=next PC, state<=FETCH.
- **Next PC.** Control inputs are sampled only in the accept cycle. Priority:
  1. `Jrn`: `Read_data_1`
  2. `Jmp`|`Jal`: {`opcplus4`[31:28], `Instruction`[25:0], 2'b00}
  3. taken branch, (`Branch`&`Zero`)|(`nBranch`&~`Zero`): `Add_result`
  4. otherwise: `opcplus4`
- **Arithmetic.** PC+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
- **Ignored inputs.** `imem_ack` is ignored outside FETCH. `inst_ready` is ignored outside HOLD.

## Timing
- First `imem_req` is asserted in the first cycle after `reset` deasserts; `imem_addr` is `RESET_PC`.
- `imem_ack` may arrive in the same cycle as `imem_req`. Minimum throughput is then 2 cycles per instruction: FETCH, HOLD.
- Each memory wait cycle adds one cycle; `imem_addr` is held constant meanwhile.
- `inst_valid` rises the cycle after the ack edge. It falls the cycle after the accept edge, and `imem_req` rises in that same cycle with the new PC.
- Back-pressure: `inst_ready`=0 holds HOLD indefinitely; no fetch is issued.
- Reset asserted mid-fetch or mid-hold: `imem_req` and `inst_valid` drop immediately (asynchronous). A pending ack is discarded and not replayed.

## Configuration
- Macro: `IFETCH_ALIGN_CHECK_EN`.
- **Defined:**
  - A computed next PC with [1:0]≠0 sends the FSM to FAULT instead of FETCH. PC is still loaded with the offending value.
  - FAULT: `fetch_fault`=1, `imem_req`=0, `inst_valid`=0; the FSM stays there until reset.
- **Undefined:**
  - Next-PC bits [1:0] are forced to 0; FAULT is unreachable.
  - `fetch_fault` is tied to 0.

## Test plan
- **Reset/first fetch:** hold `reset`=0 for 200 ns, release; ack in the first request cycle with 32'h0043_3820. Expect:
  - `imem_addr`=0;
  - `Instruction`=32'h0043_3820, `opcplus4`=4, `inst_valid`=1 the next cycle.
- **Sequential with wait states and back-pressure:** ack delayed 3 cycles; `inst_ready` low 2 cycles. Expect:
  - `imem_addr` stable throughout;
  - `Instruction` stable while `inst_valid`=1;
  - next fetch address 4.
- **Branch:** at PC=8, `Branch`=1, `Zero`=1, `Add_result`=32'h40 -> next `imem_addr`=32'h40. Repeat with `Zero`=0 -> 32'h0C. With `nBranch`=1, `Zero`=0 -> 32'h40.
- **JAL/JR priority:**
  - `Instruction`=32'h0C00_0010 at PC=32'h14 with `Jal`=1 -> `opcplus4`=32'h18, next address 32'h40.
  - `Jrn`=1 and `Jmp`=1 together with `Read_data_1`=32'h100 -> 32'h100.
- **Wrap and reset abort:**
  - PC=32'hFFFF_FFFC sequential -> next address 0.
  - Assert reset while `imem_req`=1 -> `imem_req`=0 immediately, PC back to `RESET_PC`.
- **Alignment (`IFETCH_ALIGN_CHECK_EN` defined):** `Jrn` with `Read_data_1`=32'h102 -> `fetch_fault`=1 and no further `imem_req` until reset. Undefined: next address 32'h100.

Source files
------------

// File: rtl/ifetch32_seq.sv
// rtl/ifetch32_seq.sv - MIPS instruction fetch sequencer (PC, imem req/ack, decoder hand-off)
// Optional misaligned-target trap enabled by defining IFETCH_ALIGN_CHECK_EN.
module ifetch32_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction,
  output logic [31:0] opcplus4,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        Branch,
  input  logic        nBranch,
  input  logic        Zero,
  input  logic        Jmp,
  input  logic        Jal,
  input  logic        Jrn,
  input  logic [31:0] Add_result,
  input  logic [31:0] Read_data_1,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_opcplus4;
  logic [31:0] w_target;
  logic [31:0] w_pc_nxt;
  logic        w_ack_fire;
  logic        w_accept;
  logic        w_taken;
  logic        w_misaligned;

  assign w_ack_fire = (r_state == S_FETCH) && imem_ack;
  assign w_accept   = (r_state == S_HOLD) && inst_ready;
  assign w_taken    = (Branch & Zero) | (nBranch & ~Zero);

  // Control inputs only matter in the accept cycle; jr beats j/jal beats branch.
  always_comb begin
    w_target = r_opcplus4;
    if (Jrn)
      w_target = Read_data_1;
    else if (Jmp | Jal)
      w_target = {r_opcplus4[31:28], r_instr[25:0], 2'b00};
    else if (w_taken)
      w_target = Add_result;
  end

`ifdef IFETCH_ALIGN_CHECK_EN
  assign w_pc_nxt     = w_target;
  assign w_misaligned = |w_target[1:0];
`else
  assign w_pc_nxt     = w_target & 32'hFFFF_FFFC;
  assign w_misaligned = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      r_state <= S_FETCH;
    else
      r_state <= w_state_nxt;
  end

  // Outputs are gated by reset so they drop as soon as reset asserts.
  always_comb begin
    w_state_nxt = r_state;
    imem_req    = 1'b0;
    inst_valid  = 1'b0;
    fetch_fault = 1'b0;
    case (r_state)
      S_FETCH: begin
        imem_req = reset;
        if (imem_ack)
          w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        inst_valid = reset;
        if (inst_ready)
          w_state_nxt = w_misaligned ? S_FAULT : S_FETCH;
      end
      S_FAULT: begin
`ifdef IFETCH_ALIGN_CHECK_EN
        fetch_fault = reset;
`endif
        w_state_nxt = S_FAULT;
      end
      default: w_state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc       <= RESET_PC;
      r_instr    <= 32'h0000_0000;
      r_opcplus4 <= 32'h0000_0000;
    end else begin
      if (w_ack_fire) begin
        r_instr    <= imem_rdata;
        r_opcplus4 <= r_pc + 32'd4;
      end
      if (w_accept)
        r_pc <= w_pc_nxt;
    end
  end

  assign imem_addr   = r_pc;
  assign Instruction = r_instr;
  assign opcplus4    = r_opcplus4;

endmodule
